gated_capture_pipe: RTL
=======================

# gated_capture_pipe

- Parametrised successor to the fixed enable-capture / four-flop invert chain.
- Captures `i_a` into a capture register whenever `i_en` is high, then passes it through a `DEPTH`-stage register pipeline with a per-stage inversion mask.
- Unlike the fixed chain, it adds valid tracking, stall, flush, occupancy count and dropped-capture reporting.
- Sits between a gated source and downstream sampling logic in `top`-level test designs.

## Interface

Parameters:
- `WIDTH`, 1: data width of `i_a` / `o_a`.
- `DEPTH`, 4: number of pipeline stages after the capture register; legal range 1..16.
- `INV_MASK`, 4'b1010: `DEPTH` bits. Bit k set means stage k stores the bitwise inverse of its input. Stage 0 is nearest the capture register.

Ports:
- `i_clk` in 1: single clock; all registers are rising-edge.
- `i_rst` in 1: synchronous, active-high reset.
- `i_en` in 1: capture enable.
- `i_a` in WIDTH: capture data.
- `i_stall` in 1: freeze all registers.
- `i_flush` in 1: invalidate pipeline contents.
- `o_a` out WIDTH: stage DEPTH-1 data.
- `o_valid` out 1: stage DEPTH-1 valid bit.
- `o_count` out $clog2(DEPTH+1): number of valid stages, 0..DEPTH.
- `o_drop` out 1: one-cycle pulse when a capture was lost to a stall.

## Operation

Registers: `cap_d`/`cap_v`, and per-stage `stg_d[k]`/`stg_v[k]` for k = 0..DEPTH-1.

Priority per cycle: `i_rst` > `i_stall` > normal update. `i_flush` applies in both the stall and normal cases.

Reset:
- All data, all valid bits and `o_drop` go to 0.
- Therefore `o_a`=0, `o_valid`=0, `o_count`=0 after reset.

Stall (`i_stall`=1):
- All data and valid registers hold.
- `i_en` is ignored. If `i_en`=1 in a stalled cycle, `o_drop`=1 next cycle; otherwise `o_drop`=0.

Normal (`i_stall`=0):
- `cap_d` <= `i_en` ? `i_a` : `cap_d`. The captured value is held between enables.
- `cap_v` <= `i_en`.
- `stg_d[0]` <= `cap_d` ^ {WIDTH{INV_MASK[0]}}.
- `stg_d[k]` <= `stg_d[k-1]` ^ {WIDTH{INV_MASK[k]}}.
- Valid bits shift along with the data.
- `o_drop` <= 0.

Data moves every non-stalled cycle whether or not it is valid. Because of `INV_MASK`, `o_a` may toggle after reset with no capture; only `o_valid` qualifies `o_a`.

Flush (`i_flush`=1, not in reset):
- Next cycle, `cap_v` and all `stg_v` are 0. Data registers update per the stall/normal rule.
- A capture presented in the same cycle as a flush is discarded. `o_drop` does not pulse for it.

`o_count`:
- Popcount of `stg_v[0..DEPTH-1]`, registered alongside the valid bits so it always matches the current valid state.
- Never exceeds DEPTH; no wrap.

Net polarity: `o_a` equals the captured value XOR {WIDTH{^INV_MASK}}.

## Timing

- Latency from a capture cycle t (`i_en`=1, no stall) to `o_a`/`o_valid`: t+1+DEPTH. Each stalled cycle adds one.
- Throughput: one capture per cycle. Back-to-back captures stay distinct and ordered.
- Stall release: the pipeline resumes on the first cycle with `i_stall`=0. Nothing is lost or duplicated.
- Reset asserted mid-flight clears everything on the next edge. `i_en` in the reset cycle is ignored.
- Stall and flush together: valid bits clear, data holds.

## Test plan

- Reset then idle, WIDTH=1, DEPTH=4, INV_MASK=4'b1010: hold `i_rst` 2 cycles -> `o_a`=0, `o_valid`=0, `o_count`=0, `o_drop`=0 during the cycle after release.
- Single capture, same config: `i_en`=1 with `i_a`=1 at cycle 10 -> `o_valid`=1 and `o_a`=1 at cycle 15 only. `o_count` reads 1 during cycles 12-15 and 0 at cycle 16.
- Width/mask, WIDTH=8, DEPTH=3, INV_MASK=3'b001: capture 8'h5A, then 8'h3C on consecutive cycles -> `o_a`=8'hA5 then 8'hC3 with `o_valid`=1 on two consecutive cycles. `o_count` peaks at 2.
- Stall, default config: capture 1, then `i_stall`=1 for 3 cycles starting 2 cycles later, with `i_en`=1 in the first stalled cycle -> output arrives 3 cycles late. `o_drop`=1 for exactly one cycle. Only one valid output.
- Flush: fill 4 back-to-back captures, then assert `i_flush` with `i_en`=1 -> `o_count`=0 next cycle. No further `o_valid`. `o_drop` stays 0.
- Reset mid-flight: capture at cycle 10, assert `i_rst` at cycle 12 -> `o_valid` never rises. `o_a`=0 at cycle 13.

Source files
------------

// File: rtl/gated_capture_pipe.sv
// Enable-gated capture register feeding a DEPTH-stage pipeline with per-stage inversion.
// Adds valid tracking, stall/flush control, occupancy count and dropped-capture reporting.
module gated_capture_pipe #(
    parameter int               WIDTH    = 1,
    parameter int               DEPTH    = 4,
    parameter logic [DEPTH-1:0] INV_MASK = 4'b1010,
    localparam int              CW       = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_a,
    input  logic             i_stall,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_a,
    output logic             o_valid,
    output logic [CW-1:0]    o_count,
    output logic             o_drop
);

    function automatic logic [CW-1:0] popcount(input logic [DEPTH-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int k = 0; k < DEPTH; k++) begin
            c = c + CW'(v[k]);
        end
        return c;
    endfunction

    logic [WIDTH-1:0] r_cap_d;
    logic             r_cap_v;
    logic [WIDTH-1:0] r_stg_d [DEPTH];
    logic [DEPTH-1:0] r_stg_v;
    logic [CW-1:0]    r_count;
    logic             r_drop;

    logic [WIDTH-1:0] w_cap_d;
    logic             w_adv_cap_v;
    logic [WIDTH-1:0] w_stg_d [DEPTH];
    logic [DEPTH-1:0] w_adv_stg_v;
    logic             w_cap_v;
    logic [DEPTH-1:0] w_stg_v;
    logic             w_drop;

    // Next-state: advance when not stalled, hold (and report lost captures) when stalled.
    always_comb begin
        w_cap_d     = r_cap_d;
        w_adv_cap_v = r_cap_v;
        w_stg_d     = r_stg_d;
        w_adv_stg_v = r_stg_v;
        w_drop      = 1'b0;
        if (!i_stall) begin
            w_cap_d        = i_en ? i_a : r_cap_d;
            w_adv_cap_v    = i_en;
            w_stg_d[0]     = r_cap_d ^ {WIDTH{INV_MASK[0]}};
            w_adv_stg_v[0] = r_cap_v;
            for (int k = 1; k < DEPTH; k++) begin
                w_stg_d[k]     = r_stg_d[k-1] ^ {WIDTH{INV_MASK[k]}};
                w_adv_stg_v[k] = r_stg_v[k-1];
            end
        end else begin
            // A capture coinciding with a flush is discarded silently, not dropped.
            w_drop = i_en & ~i_flush;
        end
    end

    assign w_cap_v = i_flush ? 1'b0 : w_adv_cap_v;
    assign w_stg_v = i_flush ? '0   : w_adv_stg_v;

    // State registers; count is taken from next-state valids so it tracks them exactly.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cap_d <= '0;
            r_cap_v <= 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                r_stg_d[k] <= '0;
            end
            r_stg_v <= '0;
            r_count <= '0;
            r_drop  <= 1'b0;
        end else begin
            r_cap_d <= w_cap_d;
            r_cap_v <= w_cap_v;
            r_stg_d <= w_stg_d;
            r_stg_v <= w_stg_v;
            r_count <= popcount(w_stg_v);
            r_drop  <= w_drop;
        end
    end

    assign o_a     = r_stg_d[DEPTH-1];
    assign o_valid = r_stg_v[DEPTH-1];
    assign o_count = r_count;
    assign o_drop  = r_drop;

endmodule
